shift_seq_ctl: RTL and testbench
================================

Name: shift_seq_ctl

Overview:
- Sequencer for a chain of 4-bit universal shift register slices.
- Slices share one op pair: 00 load, 01 shift toward q0 with shft3in entering, 10 shift toward q3 with shft0in entering, 11 hold.
- Accepts one command at a time over a valid/ready handshake. Drives the op pair and end-fill bits for the required number of clocks, then pulses done.
- Sits between microcode/datapath control and the shift register chain.

Parameters:
- CNTW, 6, width of the shift count; max 2**CNTW-1 shifts per command.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE with abort low.
- cmd_kind  in  2  00 LOAD, 01 SHL (toward q0), 10 SHR (toward q3), 11 NOP.
- cmd_count  in  CNTW  shift count; ignored for LOAD/NOP.
- cmd_fill  in  1  bit shifted into the vacated end.
- abort  in  1  synchronous cancel of the current command.
- sr_op1, sr_op2  out  1 each  op pair to every slice.
- sr_shft0in, sr_shft3in  out  1 each  end-fill bits to the chain ends.
- busy  out  1  high in LOAD and SHIFT.
- done  out  1  one-cycle pulse when a command completes.

Behaviour:
- States: IDLE, LOAD, SHIFT, DONE. State, remaining count, direction and fill are registers.
- Outputs are Moore-decoded from state. The op shown during a cycle is applied by the chain at the edge ending that cycle.
- Reset values (asynchronous, immediate): state IDLE, count 0, {sr_op1,sr_op2}=11, shft0in=shft3in=0, busy=0, done=0, cmd_ready=1 once rst is low.
- IDLE: op 11. Accept when cmd_valid && cmd_ready. Latch kind, count, fill.
  - LOAD goes to LOAD.
  - SHL/SHR with count>0 goes to SHIFT.
  - SHL/SHR with count==0 goes to DONE.
  - NOP goes to DONE.
- LOAD: op 00 for exactly one cycle, then DONE.
- SHIFT:
  - op 01 (SHL) or 10 (SHR) for exactly count cycles. Counter decrements each cycle; leave to DONE when it reaches 1.
  - SHL drives shft3in=fill, shft0in=0. SHR drives shft0in=fill, shft3in=0.
  - Outside SHIFT, both fill bits are 0.
- DONE: op 11, done=1 for one cycle, then IDLE.
- Latency from the accept edge:
  - LOAD: chain updated at +1 edge; done high in cycle +1..+2.
  - Shift N: chain has N shifts after edge +N; done in the following cycle.
  - The next command is accepted no earlier than the edge after DONE.
- Count max (all ones): exactly 2**CNTW-1 shifts, no wrap.
- abort high in LOAD or SHIFT: next state IDLE, no done pulse. The op shown in that cycle still applies; shifts already applied are not undone.
- abort in IDLE blocks acceptance. abort in DONE: done still pulses.
- cmd_valid and abort both high in IDLE: abort wins; no accept.
- Reset mid-command: chain sees op 11 immediately; no done pulse.
- cmd inputs are ignored outside the accept cycle.

Optional Feature:
- Macro: SHIFT_SEQ_ROTATE_EN.
- Defined:
  - Adds cmd_rot (in, 1) plus sr_q0_fb and sr_q3_fb (in, 1 each, chain end outputs).
  - cmd_rot is latched at accept.
  - SHL with rot: shft3in = sr_q0_fb, combinational pass-through.
  - SHR with rot: shft0in = sr_q3_fb.
  - Gives rotate over the whole chain; cmd_fill is ignored when rot is set.
- Undefined: ports absent; fill always from cmd_fill.

Decomposition:
- Package shift_seq_pkg:
  - sr_op_t enum: SR_LOAD=00, SR_SHFT3=01, SR_SHFT0=10, SR_HOLD=11.
  - cmd_kind_t enum.
  - state_t enum.
- No sub-module; the down-counter and decode stay inline.

Test Plan:
- Reset, then LOAD → op 00 for 1 cycle, done at cycle 2, chain of 4 slices holds 0x1234 after loading d=0x1234.
- SHL count=3 fill=1 on 0x8001 (16-bit) → 3 cycles op 01, result 0x000F, done once.
- SHR count=0 → no op other than 11; done one cycle after accept.
- SHR count=5; abort in 3rd SHIFT cycle → exactly 3 shifts, no done, cmd_ready back next cycle.
- rst asserted mid-SHIFT → op 11 immediately, busy=0, chain holds value.
- ROTATE_EN: SHL rot count=16 on 0xA5C3 → value 0xA5C3 after 16 cycles. SHR rot count=4 → 0x3A5C.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared types for the shift-register chain sequencer: slice op codes,
// command kinds and controller states.
package shift_seq_pkg;

  // Slice op pair {op1,op2}; names say which end-fill input enters the chain.
  typedef enum logic [1:0] {
    SR_LOAD  = 2'b00,
    SR_SHFT3 = 2'b01,
    SR_SHFT0 = 2'b10,
    SR_HOLD  = 2'b11
  } sr_op_t;

  typedef enum logic [1:0] {
    CMD_LOAD = 2'b00,
    CMD_SHL  = 2'b01,
    CMD_SHR  = 2'b10,
    CMD_NOP  = 2'b11
  } cmd_kind_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/shift_seq_ctl.sv
// Sequencer driving the shared op pair and end-fill bits of a shift-register
// slice chain. Optional whole-chain rotate enabled by SHIFT_SEQ_ROTATE_EN.
module shift_seq_ctl
  import shift_seq_pkg::*;
#(
  parameter int CNTW = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_kind,
  input  logic [CNTW-1:0] cmd_count,
  input  logic            cmd_fill,
`ifdef SHIFT_SEQ_ROTATE_EN
  input  logic            cmd_rot,
  input  logic            sr_q0_fb,
  input  logic            sr_q3_fb,
`endif
  input  logic            abort,
  output logic            sr_op1,
  output logic            sr_op2,
  output logic            sr_shft0in,
  output logic            sr_shft3in,
  output logic            busy,
  output logic            done
);

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            shl_q, shl_d;
  logic            fill_q, fill_d;
  logic            accept;
  logic            fill_to_q3_end;
  logic            fill_to_q0_end;
  cmd_kind_t       kind;
  sr_op_t          op;

  assign kind   = cmd_kind_t'(cmd_kind);
  assign accept = cmd_valid && cmd_ready;

`ifdef SHIFT_SEQ_ROTATE_EN
  logic rot_q, rot_d;

  // Rotate closes the loop combinationally from the far end of the chain.
  assign fill_to_q3_end = rot_q ? sr_q0_fb : fill_q;
  assign fill_to_q0_end = rot_q ? sr_q3_fb : fill_q;
`else
  assign fill_to_q3_end = fill_q;
  assign fill_to_q0_end = fill_q;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shl_q   <= 1'b0;
      fill_q  <= 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
      rot_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shl_q   <= shl_d;
      fill_q  <= fill_d;
`ifdef SHIFT_SEQ_ROTATE_EN
      rot_q   <= rot_d;
`endif
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shl_d   = shl_q;
    fill_d  = fill_q;
`ifdef SHIFT_SEQ_ROTATE_EN
    rot_d   = rot_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_d  = cmd_count;
          shl_d  = (kind == CMD_SHL);
          fill_d = cmd_fill;
`ifdef SHIFT_SEQ_ROTATE_EN
          rot_d  = cmd_rot;
`endif
          unique case (kind)
            CMD_LOAD: state_d = ST_LOAD;
            CMD_SHL,
            CMD_SHR:  state_d = (cmd_count != '0) ? ST_SHIFT : ST_DONE;
            default:  state_d = ST_DONE;
          endcase
        end
      end
      ST_LOAD: begin
        state_d = abort ? ST_IDLE : ST_DONE;
      end
      ST_SHIFT: begin
        // The shift shown in this cycle lands at the closing edge, so count 1 is the last one.
        cnt_d = cnt_q - CNTW'(1);
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNTW'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    op         = SR_HOLD;
    sr_shft0in = 1'b0;
    sr_shft3in = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    cmd_ready  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = !abort && !rst;
      end
      ST_LOAD: begin
        op   = SR_LOAD;
        busy = 1'b1;
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (shl_q) begin
          op         = SR_SHFT3;
          sr_shft3in = fill_to_q3_end;
        end else begin
          op         = SR_SHFT0;
          sr_shft0in = fill_to_q0_end;
        end
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        op = SR_HOLD;
      end
    endcase
  end

  assign {sr_op1, sr_op2} = op;

endmodule

// File: tb/tb_shift_seq_ctl.sv
// Bench for shift_seq_ctl: a 16-bit chain (four 4-bit slices) driven by the DUT,
// with a queue scoreboard fed by the stimulus side and drained by a monitor.
`timescale 1ns/1ps
module tb_shift_seq_ctl;

  localparam int CNTW = 6;
  localparam int MAXC = (1 << CNTW) - 1;
`ifdef SHIFT_SEQ_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  typedef enum int {M_NORM, M_ABORT, M_RESET, M_DONE_ABORT, M_IDLE_ABORT} mode_t;

  typedef struct {
    logic [1:0]  op;
    int          ncyc;
    logic        fill;
    logic        rot;
    logic [15:0] val;
    bit          aborted;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_valid, cmd_ready, cmd_fill, abort;
  logic [1:0]      cmd_kind;
  logic [CNTW-1:0] cmd_count;
  logic            sr_op1, sr_op2, sr_shft0in, sr_shft3in, busy, done;
  logic            cmd_rot;
  logic [15:0]     chain_q = 16'h0;
  logic [15:0]     load_d  = 16'h0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  exp_t        sb_q[$];
  exp_t        cur;
  bit          active = 1'b0;
  int          ops_seen = 0;
  int          acc_cyc = 0;
  bit          val_pending = 1'b0;
  logic [15:0] pend_val;
  logic [15:0] mdl_val = 16'h0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shift_seq_ctl #(.CNTW(CNTW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_kind   (cmd_kind),
    .cmd_count  (cmd_count),
    .cmd_fill   (cmd_fill),
`ifdef SHIFT_SEQ_ROTATE_EN
    .cmd_rot    (cmd_rot),
    .sr_q0_fb   (chain_q[15]),
    .sr_q3_fb   (chain_q[0]),
`endif
    .abort      (abort),
    .sr_op1     (sr_op1),
    .sr_op2     (sr_op2),
    .sr_shft0in (sr_shft0in),
    .sr_shft3in (sr_shft3in),
    .busy       (busy),
    .done       (done)
  );

  // Four cascaded slices: q0 end is bit 15, q3 end is bit 0.
  always @(posedge clk) begin
    case ({sr_op1, sr_op2})
      2'b00:   chain_q <= load_d;
      2'b01:   chain_q <= {chain_q[14:0], sr_shft3in};
      2'b10:   chain_q <= {sr_shft0in, chain_q[15:1]};
      default: chain_q <= chain_q;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One shift of the whole 16-bit word, written as plain arithmetic.
  function automatic logic [15:0] step(input logic [15:0] v, input logic [1:0] kind,
                                       input logic fill, input logic rot);
    int x, f;
    x = int'(v);
    if (kind == 2'b01) begin
      f = rot ? ((x >> 15) & 1) : int'(fill);
      x = ((x << 1) | f) & 'hFFFF;
    end else begin
      f = rot ? (x & 1) : int'(fill);
      x = (x >> 1) | (f << 15);
    end
    return 16'(x);
  endfunction

  // Monitor: decoupled from stimulus, pops an expectation at each accept.
  always @(negedge clk) begin
    logic [1:0] op;
    op = {sr_op1, sr_op2};
    if (rst) begin
      active      = 1'b0;
      val_pending = 1'b0;
    end else begin
      if (val_pending) begin
        check("abort_chain_value", 32'(chain_q), 32'(pend_val));
        val_pending = 1'b0;
      end
      if (active) begin
        if (op != 2'b11) begin
          ops_seen++;
          check("op_code", 32'(op), 32'(cur.op));
          check("busy_in_op", 32'(busy), 32'd1);
          if (op == 2'b01) begin
            check("shl_fill3", 32'(sr_shft3in), 32'(cur.rot ? chain_q[15] : cur.fill));
            check("shl_fill0", 32'(sr_shft0in), 32'd0);
          end else if (op == 2'b10) begin
            check("shr_fill0", 32'(sr_shft0in), 32'(cur.rot ? chain_q[0] : cur.fill));
            check("shr_fill3", 32'(sr_shft3in), 32'd0);
          end else begin
            check("load_fills", 32'({sr_shft0in, sr_shft3in}), 32'd0);
          end
        end else begin
          check("hold_fills", 32'({sr_shft0in, sr_shft3in}), 32'd0);
        end
        if (busy && abort) begin
          check("abort_shift_count", 32'(ops_seen), 32'(cur.ncyc));
          check("abort_was_planned", 32'(cur.aborted), 32'd1);
          pend_val    = cur.val;
          val_pending = 1'b1;
          active      = 1'b0;
        end else if (done) begin
          check("done_after_abort", 32'(cur.aborted), 32'd0);
          check("op_cycles", 32'(ops_seen), 32'(cur.ncyc));
          check("done_latency", 32'(cyc - acc_cyc - 1), 32'(cur.ncyc));
          check("chain_value", 32'(chain_q), 32'(cur.val));
          active = 1'b0;
        end
      end else begin
        check("idle_done", 32'(done), 32'd0);
        check("idle_op", 32'(op), 32'd3);
        check("idle_fills", 32'({sr_shft0in, sr_shft3in}), 32'd0);
      end
      if (cmd_valid && cmd_ready) begin
        check("prev_done_seen", 32'(active), 32'd0);
        check("expect_available", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
          cur      = sb_q.pop_front();
          active   = 1'b1;
          ops_seen = 0;
          acc_cyc  = cyc;
        end
      end
    end
  end

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !active && cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_timeout", 32'(ok), 32'd1);
  endtask

  task automatic issue(input logic [1:0] kind, input int count, input logic fill,
                       input logic rot, input logic [15:0] d, input mode_t mode, input int arg);
    exp_t e;
    int   n;
    bit   ok = 1'b0;
    e.op      = kind;
    e.fill    = fill;
    e.rot     = rot;
    e.aborted = (mode == M_ABORT);
    if (kind == 2'b00) begin
      n       = 1;
      mdl_val = d;
    end else if (kind == 2'b11) begin
      n = 0;
    end else begin
      n = (mode == M_ABORT) ? arg : (mode == M_RESET) ? arg - 1 : count;
      for (int i = 0; i < n; i++) mdl_val = step(mdl_val, kind, fill, rot);
    end
    e.ncyc = n;
    e.val  = mdl_val;
    if (mode == M_IDLE_ABORT) wait_idle();
    sb_q.push_back(e);

    @(posedge clk); #1;
    load_d    = d;
    cmd_kind  = kind;
    cmd_count = CNTW'(count);
    cmd_fill  = fill;
    cmd_rot   = rot;
    cmd_valid = 1'b1;
    if (mode == M_IDLE_ABORT) begin
      abort = 1'b1;
      repeat (arg) begin
        @(negedge clk);
        check("ready_blocked_by_abort", 32'(cmd_ready), 32'd0);
        check("no_accept_on_abort", 32'(busy), 32'd0);
      end
      @(posedge clk); #1;
      abort = 1'b0;
    end

    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept_timeout", 32'(ok), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_kind  = 2'($urandom);
    cmd_count = CNTW'($urandom);
    cmd_fill  = 1'($urandom);
    cmd_rot   = 1'($urandom);

    case (mode)
      M_ABORT: begin
        repeat (arg - 1) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("ready_after_abort", 32'(cmd_ready), 32'd1);
        check("busy_after_abort", 32'(busy), 32'd0);
      end
      M_RESET: begin
        repeat (arg - 1) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_op_hold", 32'({sr_op1, sr_op2}), 32'd3);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_fills", 32'({sr_shft0in, sr_shft3in}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_chain_holds", 32'(chain_q), 32'(mdl_val));
      end
      M_DONE_ABORT: begin
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
      end
      default: ;
    endcase
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_kind  = 2'b11;
    cmd_count = '0;
    cmd_fill  = 1'b0;
    cmd_rot   = 1'b0;
    abort     = 1'b0;
    #3;
    check("reset_op", 32'({sr_op1, sr_op2}), 32'd3);
    check("reset_fills", 32'({sr_shft0in, sr_shft3in}), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(cmd_ready), 32'd1);

    issue(2'b00, 0, 1'b0, 1'b0, 16'h1234, M_NORM, 0);
    issue(2'b00, 0, 1'b0, 1'b0, 16'h8001, M_NORM, 0);
    issue(2'b01, 3, 1'b1, 1'b0, 16'h0000, M_NORM, 0);
    issue(2'b10, 0, 1'b1, 1'b0, 16'h0000, M_NORM, 0);
    issue(2'b00, 0, 1'b0, 1'b0, 16'hBEEF, M_NORM, 0);
    issue(2'b10, 5, 1'b1, 1'b0, 16'h0000, M_ABORT, 3);
    issue(2'b01, 10, 1'b1, 1'b0, 16'h0000, M_RESET, 4);
    issue(2'b10, 0, 1'b0, 1'b0, 16'h0000, M_DONE_ABORT, 0);
    issue(2'b11, 7, 1'b1, 1'b0, 16'h0000, M_IDLE_ABORT, 3);
    issue(2'b00, 0, 1'b0, 1'b0, 16'h5AA5, M_NORM, 0);
    issue(2'b10, MAXC, 1'b1, 1'b0, 16'h0000, M_NORM, 0);
    issue(2'b01, MAXC, 1'b0, 1'b0, 16'h0000, M_NORM, 0);
    if (ROT) begin
      issue(2'b00, 0, 1'b0, 1'b0, 16'hA5C3, M_NORM, 0);
      issue(2'b01, 16, 1'b0, 1'b1, 16'h0000, M_NORM, 0);
      issue(2'b10, 4, 1'b1, 1'b1, 16'h0000, M_NORM, 0);
    end

    for (int i = 0; i < 40; i++) begin
      logic [1:0] k;
      int         c;
      mode_t      m;
      int         a;
      k = 2'($urandom);
      c = ($urandom_range(0, 9) == 0) ? MAXC : int'($urandom_range(0, 12));
      m = M_NORM;
      a = 0;
      if ((k == 2'b01 || k == 2'b10) && c > 0 && $urandom_range(0, 4) == 0) begin
        m = M_ABORT;
        a = int'($urandom_range(1, c));
      end
      issue(k, c, 1'($urandom), ROT ? 1'($urandom) : 1'b0, 16'($urandom), m, a);
    end

    wait_idle();
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
